// File: rtl/mux2_arbiter_pkg.sv
// Shared constants for the 2:1 arbitrated mux: source encodings and output-register FSM states.
package mux_arb_pkg;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mux2_arbiter_if.sv
// Bundles both requester handshakes and the consumer handshake of mux2_arbiter.
interface mux2_arbiter_if #(
  parameter int W = 8
);
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] q_data;
  logic         q_valid;
  logic         q_ready;
  logic         q_src;

  modport slave (
    input  a_data, a_valid, b_data, b_valid, q_ready,
    output a_ready, b_ready, q_data, q_valid, q_src
  );

  modport master (
    output a_data, a_valid, b_data, b_valid, q_ready,
    input  a_ready, b_ready, q_data, q_valid, q_src
  );
endinterface

// File: rtl/mux2_arbiter_mux2_1.sv
// Plain W-bit 2:1 mux; i_sel=1 picks i_b.
module mux2_1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_q
);
  assign o_q = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbitrated 2:1 mux into a 1-entry output register.
// Optional burst grants enabled by defining MUX_ARB_BURST_EN.
module mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux2_arbiter_if.slave  bus
);
  arb_state_e   r_state, w_state_nxt;
  logic [W-1:0] r_q_data;
  logic         r_q_src;
  logic         r_last_gnt;

  logic         w_out_free;
  logic         w_both;
  logic         w_contend_b;
  logic         w_gnt_a, w_gnt_b, w_accept;
  logic [W-1:0] w_mux;

  assign w_out_free = (r_state == EMPTY) | bus.q_ready;
  assign w_both     = bus.a_valid & bus.b_valid;

`ifdef MUX_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] r_burst_cnt;
  logic          w_keep;
  logic          w_grantee_valid;

  // cnt==0 means no live burst, so the reset state (last=B, cnt=0) lets A win first.
  assign w_keep          = (r_burst_cnt != '0) && (r_burst_cnt < CW'(BURST_LEN));
  assign w_contend_b     = w_keep ? (r_last_gnt == SRC_B) : (r_last_gnt == SRC_A);
  assign w_grantee_valid = (r_last_gnt == SRC_B) ? bus.b_valid : bus.a_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      if (w_gnt_b == r_last_gnt)
        r_burst_cnt <= (r_burst_cnt == CW'(BURST_LEN)) ? r_burst_cnt : r_burst_cnt + CW'(1);
      else
        r_burst_cnt <= CW'(1);
    end else if (!w_grantee_valid) begin
      r_burst_cnt <= '0;
    end
  end
`else
  logic w_unused_burst;
  assign w_unused_burst = ^BURST_LEN;
  assign w_contend_b    = (r_last_gnt == SRC_A);
`endif

  // No grant while the register is blocked or during reset.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_out_free && !rst) begin
      if (w_both) begin
        w_gnt_b = w_contend_b;
        w_gnt_a = !w_contend_b;
      end else if (bus.a_valid) begin
        w_gnt_a = 1'b1;
      end else if (bus.b_valid) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  assign w_accept    = w_gnt_a | w_gnt_b;
  assign bus.a_ready = w_gnt_a;
  assign bus.b_ready = w_gnt_b;

  mux2_1 #(.W(W)) u_mux (
    .i_a   (bus.a_data),
    .i_b   (bus.b_data),
    .i_sel (w_gnt_b),
    .o_q   (w_mux)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (!w_accept && bus.q_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_q_data   <= '0;
      r_q_src    <= SRC_A;
      r_last_gnt <= SRC_B;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_q_data   <= w_mux;
        r_q_src    <= w_gnt_b;
        r_last_gnt <= w_gnt_b;
      end
    end
  end

  assign bus.q_data  = r_q_data;
  assign bus.q_valid = (r_state == FULL);
  assign bus.q_src   = r_q_src;
endmodule
